// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU issue controller.
//   fpu_cmd_t : one queued FPU command (opcode, two source regs, destination reg, immediate)
//   state_t   : issue sequencer states
//   FPU_OP*   : FPU opcodes
package fpu_ctrl_pkg;

    localparam logic [5:0] FPU_OPSET  = 6'h01;
    localparam logic [5:0] FPU_OPFADD = 6'h02;
    localparam logic [5:0] FPU_OPFSUB = 6'h03;
    localparam logic [5:0] FPU_OPFMUL = 6'h04;
    localparam logic [5:0] FPU_OPFDIV = 6'h05;
    localparam logic [5:0] FPU_OPFCMP = 6'h06;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  x1;
        logic [4:0]  x2;
        logic [4:0]  y;
        logic [31:0] data;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Ready/valid bus between the issue controller and the single-issue FPU.
//   operation, x1, x2, y, in_data, ready : controller -> FPU
//   valid, out_data, cond                : FPU -> controller
// master = controller side, slave = FPU side.
interface fpu_issue_ctrl_if;
    logic [5:0]  operation;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] in_data;
    logic        ready;
    logic        valid;
    logic [31:0] out_data;
    logic        cond;

    modport master (
        output operation, x1, x2, y, in_data, ready,
        input  valid, out_data, cond
    );

    modport slave (
        input  operation, x1, x2, y, in_data, ready,
        output valid, out_data, cond
    );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO of fpu_cmd_t.
//   push/wdata : write one command (ignored when full)
//   pop/rdata  : rdata always shows the head; pop advances it (ignored when empty)
//   full/empty : derived from (log2(DEPTH)+1)-bit pointers, MSB distinguishes wrap
module fpu_cmd_fifo
    import fpu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  fpu_cmd_t wdata,
    input  logic     pop,
    output fpu_cmd_t rdata,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    fpu_cmd_t    mem_r [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rptr_r[AW-1:0]];

    // Read/write pointers; natural wrap of the extra MSB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences queued FPU commands onto the single-issue FPU, one at a time,
// and returns each result (or a watchdog abort) on a response channel.
//   clk, rstn            : clock, asynchronous active-low reset
//   cmd_*                : command channel from the core (cmd_ready = FIFO not full)
//   fpu                  : FPU ready/valid bus (fields registered, stable while ready)
//   resp_*               : response channel back to the core
//   busy                 : commands queued or an op in flight
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [5:0]               cmd_op,
    input  logic [4:0]               cmd_x1,
    input  logic [4:0]               cmd_x2,
    input  logic [4:0]               cmd_y,
    input  logic [31:0]              cmd_data,
    fpu_issue_ctrl_if.master         fpu,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_cond,
    output logic                     resp_err,
    output logic                     busy
);
    localparam int WD_W = $clog2(TIMEOUT);

    fpu_cmd_t        push_cmd_s;
    fpu_cmd_t        head_cmd_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic            abort_s;
    logic            resp_done_s;
    logic            timeout_s;
    state_t          state_r;
    state_t          state_next_s;
    fpu_cmd_t        cur_r;
    logic            fpu_ready_r;
    logic [WD_W-1:0] wd_r;
    logic            resp_valid_r;
    logic [31:0]     resp_data_r;
    logic            resp_cond_r;
    logic            resp_err_r;

    assign push_cmd_s = '{op: cmd_op, x1: cmd_x1, x2: cmd_x2, y: cmd_y, data: cmd_data};
    assign cmd_ready  = !fifo_full_s;
    // No push-through: a full FIFO refuses even when a pop happens on the same edge.
    assign push_s     = cmd_valid && !fifo_full_s;
    assign timeout_s  = (wd_r == WD_W'(TIMEOUT - 1));

    fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .wdata (push_cmd_s),
        .pop   (pop_s),
        .rdata (head_cmd_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        abort_s      = 1'b0;
        resp_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                // A result arriving on the timeout edge is still accepted.
                if (fpu.valid) begin
                    capture_s    = 1'b1;
                    state_next_s = RESP;
                end else if (timeout_s) begin
                    abort_s      = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_done_s = 1'b1;
                    // Back-to-back issue straight from RESP when work is queued.
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = ISSUE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FPU-side registers: op fields load only on pop, so they hold while ready is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_r       <= '0;
            fpu_ready_r <= 1'b0;
            wd_r        <= '0;
        end else begin
            if (pop_s) begin
                cur_r       <= head_cmd_s;
                fpu_ready_r <= 1'b1;
                wd_r        <= '0;
            end else if (capture_s || abort_s) begin
                fpu_ready_r <= 1'b0;
            end else if (state_r == ISSUE) begin
                wd_r <= wd_r + WD_W'(1);
            end
        end
    end

    // Response registers: held until the core handshakes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            resp_cond_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                resp_valid_r <= 1'b1;
                resp_data_r  <= fpu.out_data;
                resp_cond_r  <= fpu.cond;
                resp_err_r   <= 1'b0;
            end else if (abort_s) begin
                resp_valid_r <= 1'b1;
                resp_data_r  <= 32'h0000_0000;
                resp_cond_r  <= 1'b0;
                resp_err_r   <= 1'b1;
            end else if (resp_done_s) begin
                resp_valid_r <= 1'b0;
            end
        end
    end

    assign fpu.operation = cur_r.op;
    assign fpu.x1        = cur_r.x1;
    assign fpu.x2        = cur_r.x2;
    assign fpu.y         = cur_r.y;
    assign fpu.in_data   = cur_r.data;
    assign fpu.ready     = fpu_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_data     = resp_data_r;
    assign resp_cond     = resp_cond_r;
    assign resp_err      = resp_err_r;
    assign busy          = !fifo_empty_s || (state_r != IDLE);
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_op;
    logic [4:0]  cmd_x1;
    logic [4:0]  cmd_x2;
    logic [4:0]  cmd_y;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_cond;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fpu_issue_ctrl_if fpu_if ();

    fpu_issue_ctrl #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x1     (cmd_x1),
        .cmd_x2     (cmd_x2),
        .cmd_y      (cmd_y),
        .cmd_data   (cmd_data),
        .fpu        (fpu_if),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_cond  (resp_cond),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                        input logic [4:0] y, input logic [31:0] data);
        cmd_op    = op;
        cmd_x1    = x1;
        cmd_x2    = x2;
        cmd_y     = y;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rstn            = 1'b0;
        cmd_valid       = 1'b0;
        cmd_op          = 6'd0;
        cmd_x1          = 5'd0;
        cmd_x2          = 5'd0;
        cmd_y           = 5'd0;
        cmd_data        = 32'h0;
        resp_ready      = 1'b0;
        fpu_if.valid    = 1'b0;
        fpu_if.out_data = 32'h0;
        fpu_if.cond     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 32'd1);
        check("rst_fpu_ready", fpu_if.ready, 32'd0);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_fpu_op", fpu_if.operation, 32'd0);
        rstn = 1'b1;
        tick();

        // Single OPSET: valid three cycles after ready, fields held meanwhile
        push(FPU_OPSET, 5'd0, 5'd0, 5'd1, 32'h3f80_0000);
        check("set_ready_e0", fpu_if.ready, 32'd0);
        check("set_busy_e0", busy, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("set_ready_hold", fpu_if.ready, 32'd1);
            check("set_op_hold", fpu_if.operation, {26'd0, FPU_OPSET});
            check("set_y_hold", fpu_if.y, 32'd1);
            check("set_data_hold", fpu_if.in_data, 32'h3f80_0000);
            if (i == 2) begin
                fpu_if.valid    = 1'b1;
                fpu_if.out_data = 32'h3f80_0000;
                fpu_if.cond     = 1'b0;
            end
            tick();
        end
        fpu_if.valid = 1'b0;
        check("set_ready_drop", fpu_if.ready, 32'd0);
        check("set_resp_valid", resp_valid, 32'd1);
        check("set_resp_data", resp_data, 32'h3f80_0000);
        check("set_resp_err", resp_err, 32'd0);
        tick();
        check("set_resp_held", resp_valid, 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("set_resp_drop", resp_valid, 32'd0);
        check("set_idle_busy", busy, 32'd0);

        // FMUL path with cond
        push(FPU_OPFMUL, 5'd0, 5'd1, 5'd2, 32'h0);
        tick();
        check("fmul_ready", fpu_if.ready, 32'd1);
        check("fmul_op", fpu_if.operation, {26'd0, FPU_OPFMUL});
        check("fmul_x1", fpu_if.x1, 32'd0);
        check("fmul_x2", fpu_if.x2, 32'd1);
        check("fmul_y", fpu_if.y, 32'd2);
        fpu_if.valid    = 1'b1;
        fpu_if.out_data = 32'h402e_147b;
        fpu_if.cond     = 1'b1;
        tick();
        fpu_if.valid = 1'b0;
        fpu_if.cond  = 1'b0;
        check("fmul_resp_data", resp_data, 32'h402e_147b);
        check("fmul_resp_cond", resp_cond, 32'd1);
        check("fmul_resp_err", resp_err, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Spurious valid in IDLE is ignored
        fpu_if.valid    = 1'b1;
        fpu_if.out_data = 32'hdead_beef;
        tick();
        fpu_if.valid = 1'b0;
        tick();
        check("spur_resp_valid", resp_valid, 32'd0);
        check("spur_fpu_ready", fpu_if.ready, 32'd0);
        check("spur_busy", busy, 32'd0);

        // Queue: five pushes, four buffered plus one in flight
        for (int i = 0; i < 5; i++) begin
            cmd_op    = FPU_OPFADD;
            cmd_x1    = 5'(i);
            cmd_x2    = 5'(i);
            cmd_y     = 5'(i);
            cmd_data  = 32'h100 + 32'(i);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("q_full_cmd_ready", cmd_ready, 32'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("q_issue_ready", fpu_if.ready, 32'd1);
            check("q_issue_data", fpu_if.in_data, 32'h100 + 32'(k));
            fpu_if.valid    = 1'b1;
            fpu_if.out_data = 32'ha000 + 32'(k);
            tick();
            fpu_if.valid = 1'b0;
            check("q_resp_valid", resp_valid, 32'd1);
            check("q_resp_data", resp_data, 32'ha000 + 32'(k));
            check("q_ready_low", fpu_if.ready, 32'd0);
            tick();
        end
        resp_ready = 1'b0;
        check("q_drain_busy", busy, 32'd0);
        check("q_drain_resp", resp_valid, 32'd0);
        check("q_drain_cmd_ready", cmd_ready, 32'd1);

        // Timeout, then the queued op issues normally
        push(FPU_OPFADD, 5'd3, 5'd4, 5'd5, 32'h55);
        push(FPU_OPFSUB, 5'd6, 5'd7, 5'd8, 32'h66);
        cnt = 0;
        while (fpu_if.ready === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        check("to_ready_cycles", 32'(cnt), 32'(TIMEOUT));
        check("to_resp_valid", resp_valid, 32'd1);
        check("to_resp_err", resp_err, 32'd1);
        check("to_resp_data", resp_data, 32'h0);
        check("to_resp_cond", resp_cond, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("to_next_ready", fpu_if.ready, 32'd1);
        check("to_next_data", fpu_if.in_data, 32'h66);
        check("to_resp_drop", resp_valid, 32'd0);

        // Valid coinciding with the timeout edge wins
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
        end
        check("late_ready_hold", fpu_if.ready, 32'd1);
        check("late_data_hold", fpu_if.in_data, 32'h66);
        fpu_if.valid    = 1'b1;
        fpu_if.out_data = 32'h1234_abcd;
        fpu_if.cond     = 1'b1;
        tick();
        fpu_if.valid = 1'b0;
        fpu_if.cond  = 1'b0;
        check("late_resp_valid", resp_valid, 32'd1);
        check("late_resp_err", resp_err, 32'd0);
        check("late_resp_data", resp_data, 32'h1234_abcd);
        check("late_resp_cond", resp_cond, 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset mid-ISSUE with a second command queued
        push(FPU_OPFDIV, 5'd1, 5'd2, 5'd3, 32'h77);
        push(FPU_OPFCMP, 5'd4, 5'd5, 5'd6, 32'h88);
        check("mid_ready_pre", fpu_if.ready, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_fpu_ready", fpu_if.ready, 32'd0);
        check("mid_rst_resp_valid", resp_valid, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("mid_rel_cmd_ready", cmd_ready, 32'd1);
        tick();
        tick();
        check("mid_rel_busy", busy, 32'd0);
        check("mid_rel_resp_valid", resp_valid, 32'd0);
        check("mid_rel_fpu_ready", fpu_if.ready, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
